// File: rtl/eth_tx_pkt_gen_pkg.sv
// Shared constants for the Avalon-ST TX packet generator:
// CSR map, CTRL bit positions, FSM encodings and reset defaults.
package eth_tx_pkt_gen_pkg;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_NUM      = 3'd1;
    localparam logic [2:0] ADDR_LEN      = 3'd2;
    localparam logic [2:0] ADDR_GAP      = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;
    localparam logic [2:0] ADDR_PKT_CNT  = 3'd5;
    localparam logic [2:0] ADDR_BEAT_CNT = 3'd6;
    localparam logic [2:0] ADDR_RSVD     = 3'd7;

    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_ERR   = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int unsigned DEF_LEN = 64;
    localparam int unsigned DEF_NUM = 1;
    localparam int unsigned DEF_GAP = 0;

    // Unused bytes on the last beat: (8 - len%8) % 8.
    function automatic logic [2:0] eop_empty(input logic [2:0] len_lsb);
        return 3'd0 - len_lsb;
    endfunction

endpackage

// File: rtl/eth_tx_pkt_gen_csr.sv
// CSR register file for the packet generator: config registers,
// start/stop pulses and the one-cycle readdata pipe.
module eth_tx_pkt_gen_csr
    import eth_tx_pkt_gen_pkg::*;
#(
    parameter int LEN_W   = 14,
    parameter int MAX_LEN = 9600,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       csr_address,
    input  logic             csr_read,
    input  logic             csr_write,
    input  logic [31:0]      csr_writedata,
    output logic [31:0]      csr_readdata,
    input  logic             busy,
    input  logic [CNT_W-1:0] pkt_cnt,
    input  logic [CNT_W-1:0] beat_cnt,
    output logic             start,
    output logic             stop,
    output logic             err_sample,
    output logic [CNT_W-1:0] num_pkts,
    output logic [LEN_W-1:0] pkt_len,
    output logic [15:0]      gap_len
);

    logic             err_q, err_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [15:0]      gap_q, gap_d;
    logic [31:0]      rdata_q, rdata_d;

    logic wr_ctrl, wr_num, wr_len, wr_gap;

    assign wr_ctrl = csr_write && (csr_address == ADDR_CTRL);
    assign wr_num  = csr_write && (csr_address == ADDR_NUM) && !busy;
    assign wr_len  = csr_write && (csr_address == ADDR_LEN) && !busy
                     && (csr_writedata != 32'd0);
    assign wr_gap  = csr_write && (csr_address == ADDR_GAP) && !busy;

    assign start = wr_ctrl && csr_writedata[CTRL_START];
    assign stop  = wr_ctrl && csr_writedata[CTRL_STOP];

    // A start write may set inject_err in the same beat it launches.
    assign err_sample = wr_ctrl ? csr_writedata[CTRL_ERR] : err_q;

    always_comb begin
        err_d = err_q;
        num_d = num_q;
        len_d = len_q;
        gap_d = gap_q;
        unique case (1'b1)
            wr_ctrl: err_d = csr_writedata[CTRL_ERR];
            wr_num:  num_d = CNT_W'(csr_writedata);
            wr_len: begin
                if (csr_writedata > 32'(MAX_LEN))
                    len_d = LEN_W'(MAX_LEN);
                else
                    len_d = LEN_W'(csr_writedata);
            end
            wr_gap:  gap_d = csr_writedata[15:0];
            default: ;
        endcase
    end

    // Sampled from current state, so a same-cycle write reads back the old value.
    always_comb begin
        rdata_d = 32'd0;
        if (csr_read) begin
            unique case (csr_address)
                ADDR_CTRL:     rdata_d = {29'd0, err_q, 2'b00};
                ADDR_NUM:      rdata_d = 32'(num_q);
                ADDR_LEN:      rdata_d = 32'(len_q);
                ADDR_GAP:      rdata_d = {16'd0, gap_q};
                ADDR_STATUS:   rdata_d = {31'd0, busy};
                ADDR_PKT_CNT:  rdata_d = 32'(pkt_cnt);
                ADDR_BEAT_CNT: rdata_d = 32'(beat_cnt);
                ADDR_RSVD:     rdata_d = 32'd0;
                default:       rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            num_q   <= CNT_W'(DEF_NUM);
            len_q   <= LEN_W'(DEF_LEN);
            gap_q   <= 16'(DEF_GAP);
            rdata_q <= 32'd0;
        end else begin
            err_q   <= err_d;
            num_q   <= num_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            rdata_q <= rdata_d;
        end
    end

    assign csr_readdata = rdata_q;
    assign num_pkts     = num_q;
    assign pkt_len      = len_q;
    assign gap_len      = gap_q;

endmodule

// File: rtl/eth_tx_pkt_gen.sv
// Programmable Avalon-ST packet generator: emits NUM packets of LEN bytes
// carrying {pkt_seq, beat_idx}, with an optional idle gap between packets.
module eth_tx_pkt_gen
    import eth_tx_pkt_gen_pkg::*;
#(
    parameter  int DATA_W  = 64,
    parameter  int LEN_W   = 14,
    parameter  int MAX_LEN = 9600,
    parameter  int CNT_W   = 32,
    localparam int EMPTY_W = $clog2(DATA_W / 8)
) (
    input  logic               clk_clk,
    input  logic               clk_reset_reset,
    input  logic [2:0]         csr_address,
    input  logic               csr_read,
    input  logic               csr_write,
    output logic [31:0]        csr_readdata,
    input  logic [31:0]        csr_writedata,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty,
    output logic               out_error
);

    logic             start, stop, err_sample, busy;
    logic [CNT_W-1:0] num_pkts;
    logic [LEN_W-1:0] pkt_len;
    logic [15:0]      gap_len;

    logic [1:0]       state_q, state_d;
    logic [31:0]      seq_q, seq_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [15:0]      gap_q, gap_d;
    logic             stop_q, stop_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [LEN_W-1:0] last_beat;
    logic             is_last, fire, pkt_final, run_done;

    eth_tx_pkt_gen_csr #(
        .LEN_W   (LEN_W),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) u_csr (
        .clk           (clk_clk),
        .rst           (clk_reset_reset),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .busy          (busy),
        .pkt_cnt       (pkt_cnt_q),
        .beat_cnt      (beat_cnt_q),
        .start         (start),
        .stop          (stop),
        .err_sample    (err_sample),
        .num_pkts      (num_pkts),
        .pkt_len       (pkt_len),
        .gap_len       (gap_len)
    );

    // ceil(len/8)-1 == floor((len-1)/8) since len is never 0.
    assign last_beat = (pkt_len - LEN_W'(1)) >> 3;
    assign is_last   = (beat_q == last_beat);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_SEND);
    assign fire      = out_valid && out_ready;
    assign pkt_final = (num_pkts != '0)
                       && ((CNT_W'(seq_q) + CNT_W'(1)) == num_pkts);
    assign run_done  = pkt_final || stop_q || stop;

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        beat_d     = beat_q;
        gap_d      = gap_q;
        stop_d     = stop_q;
        err_d      = err_q;
        pkt_cnt_d  = pkt_cnt_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SEND;
                    seq_d      = 32'd0;
                    beat_d     = '0;
                    stop_d     = 1'b0;
                    err_d      = err_sample;
                    pkt_cnt_d  = '0;
                    beat_cnt_d = '0;
                end
            end
            ST_SEND: begin
                if (stop)
                    stop_d = 1'b1;
                if (fire) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    beat_d     = beat_q + LEN_W'(1);
                    if (is_last) begin
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                        beat_d    = '0;
                        if (run_done) begin
                            state_d = ST_IDLE;
                        end else begin
                            seq_d = seq_q + 32'd1;
                            if (gap_len != 16'd0) begin
                                state_d = ST_GAP;
                                gap_d   = gap_len;
                            end else begin
                                err_d = err_sample;
                            end
                        end
                    end
                end
            end
            ST_GAP: begin
                // A stop seen between packets ends the run before the next sop.
                if (stop || stop_q) begin
                    state_d = ST_IDLE;
                end else if (gap_q == 16'd1) begin
                    state_d = ST_SEND;
                    err_d   = err_sample;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (clk_reset_reset) begin
            state_q    <= ST_IDLE;
            seq_q      <= 32'd0;
            beat_q     <= '0;
            gap_q      <= 16'd0;
            stop_q     <= 1'b0;
            err_q      <= 1'b0;
            pkt_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            beat_q     <= beat_d;
            gap_q      <= gap_d;
            stop_q     <= stop_d;
            err_q      <= err_d;
            pkt_cnt_q  <= pkt_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign out_data          = out_valid ? DATA_W'({seq_q, 32'(beat_q)}) : '0;
    assign out_startofpacket = out_valid && (beat_q == '0);
    assign out_endofpacket   = out_valid && is_last;
    assign out_empty         = out_endofpacket
                               ? EMPTY_W'(eop_empty(pkt_len[2:0])) : '0;
    assign out_error         = out_endofpacket && err_q;

endmodule

// File: tb/tb_eth_tx_pkt_gen.sv
// Scoreboard bench for eth_tx_pkt_gen: directed CSR programs push expected
// beats; a negedge monitor pops and compares every transferred beat.
module tb_eth_tx_pkt_gen;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic        err;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  csr_address = 3'd0;
    logic        csr_read = 1'b0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_readdata;
    logic [31:0] csr_writedata = 32'd0;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic [2:0]  out_empty;
    logic        out_error;

    beat_t sb[$];
    int    xcyc[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    xfers = 0;
    bit    rand_rdy = 1'b0;
    logic  stall = 1'b0;
    beat_t held;

    eth_tx_pkt_gen dut (
        .clk_clk           (clk),
        .clk_reset_reset   (rst),
        .csr_address       (csr_address),
        .csr_read          (csr_read),
        .csr_write         (csr_write),
        .csr_readdata      (csr_readdata),
        .csr_writedata     (csr_writedata),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty),
        .out_error         (out_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        beat_t o, e;
        cyc++;
        o = {out_data, out_startofpacket, out_endofpacket, out_empty, out_error};
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_hold", 64'(o != held), 64'd0);
            end
            if (out_valid && out_ready) begin
                xfers++;
                xcyc.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=%0h required=none", o.data);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", o.data, e.data);
                    chk("sb_flags", 64'({o.sop, o.eop, o.empty, o.err}),
                        64'({e.sop, e.eop, e.empty, e.err}));
                end
            end
            stall = out_valid && !out_ready;
            held  = o;
        end
    end

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        @(posedge clk);
        #1;
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        @(posedge clk);
        #1;
        csr_address = a;
        csr_read    = 1'b1;
        @(posedge clk);
        #1;
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        csr_rd(a, d);
        chk(name, 64'(d), 64'(exp));
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int n = 0;
        do begin
            csr_rd(3'd4, s);
            n++;
        end while (s[0] && n < 3000);
        chk("idle_wait", 64'(s[0]), 64'd0);
    endtask

    task automatic wait_xfers(input int target);
        int k = 0;
        while (xfers < target && k < 2000) begin
            @(posedge clk);
            k++;
        end
        chk("xfer_wait", 64'(xfers >= target), 64'd1);
    endtask

    task automatic push_pkt(input int seq, input int len, input bit err);
        int nb = (len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            beat_t e;
            e.data  = {32'(seq), 32'(b)};
            e.sop   = (b == 0);
            e.eop   = (b == nb - 1);
            e.empty = e.eop ? 3'((8 - len % 8) % 8) : 3'd0;
            e.err   = e.eop && err;
            sb.push_back(e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int bad;
        int base;
        int diff;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_flags", 64'({out_startofpacket, out_endofpacket, out_empty, out_error}), 64'd0);
        rd_chk("rst_len", 3'd2, 32'd64);
        rd_chk("rst_num", 3'd1, 32'd1);
        rd_chk("rst_gap", 3'd3, 32'd0);
        rd_chk("rst_ctrl", 3'd0, 32'd0);
        rd_chk("rst_status", 3'd4, 32'd0);
        rd_chk("rst_pkt_cnt", 3'd5, 32'd0);
        rd_chk("rst_rsvd", 3'd7, 32'd0);

        // Three back-to-back 64-byte packets
        csr_wr(3'd2, 32'd64);
        csr_wr(3'd1, 32'd3);
        csr_wr(3'd3, 32'd0);
        for (int p = 0; p < 3; p++) push_pkt(p, 64, 1'b0);
        xcyc.delete();
        csr_wr(3'd0, 32'd1);
        wait_idle();
        chk("b2b_sb_left", 64'(sb.size()), 64'd0);
        chk("b2b_xfers", 64'(xcyc.size()), 64'd24);
        bad = 0;
        for (int i = 1; i < xcyc.size(); i++)
            if (xcyc[i] - xcyc[i-1] != 1) bad++;
        chk("b2b_contig", 64'(bad), 64'd0);
        rd_chk("b2b_pkt_cnt", 3'd5, 32'd3);
        rd_chk("b2b_beat_cnt", 3'd6, 32'd24);

        // 61 bytes: eop data 0x7 with empty 3
        csr_wr(3'd2, 32'd61);
        csr_wr(3'd1, 32'd1);
        push_pkt(0, 61, 1'b0);
        csr_wr(3'd0, 32'd1);
        wait_idle();
        chk("len61_sb_left", 64'(sb.size()), 64'd0);
        rd_chk("len61_beat_cnt", 3'd6, 32'd8);
        rd_chk("len61_pkt_cnt", 3'd5, 32'd1);

        // Two single-beat packets with a 4-cycle gap
        csr_wr(3'd2, 32'd5);
        csr_wr(3'd1, 32'd2);
        csr_wr(3'd3, 32'd4);
        push_pkt(0, 5, 1'b0);
        push_pkt(1, 5, 1'b0);
        xcyc.delete();
        csr_wr(3'd0, 32'd1);
        wait_idle();
        chk("gap_sb_left", 64'(sb.size()), 64'd0);
        diff = (xcyc.size() == 2) ? xcyc[1] - xcyc[0] : -1;
        chk("gap_spacing", 64'(diff), 64'd5);
        csr_wr(3'd3, 32'd0);

        // Random backpressure
        csr_wr(3'd2, 32'd64);
        csr_wr(3'd1, 32'd1);
        push_pkt(0, 64, 1'b0);
        rand_rdy = 1'b1;
        csr_wr(3'd0, 32'd1);
        wait_idle();
        rand_rdy = 1'b0;
        chk("rand_sb_left", 64'(sb.size()), 64'd0);
        rd_chk("rand_beat_cnt", 3'd6, 32'd8);

        // Run-forever then stop inside the third packet
        csr_wr(3'd1, 32'd0);
        for (int p = 0; p < 3; p++) push_pkt(p, 64, 1'b0);
        base = xfers;
        csr_wr(3'd0, 32'd1);
        wait_xfers(base + 2);
        csr_wr(3'd2, 32'd32);
        wait_xfers(base + 18);
        csr_wr(3'd0, 32'd2);
        wait_idle();
        chk("stop_sb_left", 64'(sb.size()), 64'd0);
        rd_chk("stop_pkt_cnt", 3'd5, 32'd3);
        rd_chk("stop_beat_cnt", 3'd6, 32'd24);
        rd_chk("busy_len_write", 3'd2, 32'd64);

        // Error injection on a 2-beat packet
        csr_wr(3'd0, 32'd4);
        csr_wr(3'd2, 32'd16);
        csr_wr(3'd1, 32'd1);
        push_pkt(0, 16, 1'b1);
        csr_wr(3'd0, 32'd5);
        wait_idle();
        chk("err_sb_left", 64'(sb.size()), 64'd0);
        rd_chk("err_ctrl", 3'd0, 32'd4);

        // Reset in the middle of a packet
        csr_wr(3'd0, 32'd0);
        csr_wr(3'd2, 32'd40);
        csr_wr(3'd1, 32'd0);
        csr_wr(3'd3, 32'd2);
        push_pkt(0, 40, 1'b0);
        base = xfers;
        csr_wr(3'd0, 32'd1);
        wait_xfers(base + 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_data", out_data, 64'd0);
        rst = 1'b0;
        sb.delete();
        rd_chk("rst_mid_len", 3'd2, 32'd64);
        rd_chk("rst_mid_num", 3'd1, 32'd1);
        rd_chk("rst_mid_gap", 3'd3, 32'd0);
        rd_chk("rst_mid_status", 3'd4, 32'd0);
        rd_chk("rst_mid_beat_cnt", 3'd6, 32'd0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
